// File: rtl/circuit_sweep_pkg.sv
// Shared types, sizes and bit-counting helpers for the circuit sweep controller.
package circuit_sweep_pkg;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] popcount8(input logic [NUM_VEC-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_VEC; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Scanning from the top down leaves the lowest set index in r.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_VEC-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = NUM_VEC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Load/decrement settle timer with zero flag; times the DRIVE phase of each vector.
module sweep_settle_cnt
  import circuit_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Counter register: load wins over decrement, never underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// Sweeps all 8 input vectors of a 3-input circuit and captures its truth table.
// Optional golden-table compare is enabled with macro SWEEP_COMPARE_EN.
module circuit_sweep_ctrl
  import circuit_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   expected,
  input  logic         y,
  output logic         a,
  output logic         b,
  output logic         c,
  output logic         busy,
  output logic         done,
  output logic [7:0]   table_out,
  output logic         pass,
  output logic [3:0]   mismatch_cnt,
  output logic [2:0]   fail_idx
);

  // Loading SETTLE_CYCLES-1 makes DRIVE last exactly SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_zero;
  logic             last_vec;
  logic [7:0]       table_next;

`ifdef SWEEP_COMPARE_EN
  logic [7:0]       exp_r;
  logic [7:0]       diff;
  assign diff = table_next ^ exp_r;
`else
  logic             unused_expected;
  assign unused_expected = ^expected;
  assign mismatch_cnt    = 4'd0;
  assign fail_idx        = 3'd0;
`endif

  assign last_vec = (idx == 3'd7);

  sweep_settle_cnt u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .cnt      (settle_cnt),
    .zero     (settle_zero)
  );

  // Timer control and the table as it will look after this cycle's sample.
  always_comb begin
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    table_next      = table_out;
    table_next[idx] = y;
    case (state)
      IDLE:    cnt_load = start;
      DRIVE:   cnt_dec  = !settle_zero;
      SAMPLE:  cnt_load = !last_vec;
      DONE:    cnt_load = 1'b0;
      default: cnt_load = 1'b0;
    endcase
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      {a, b, c} <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= 8'd0;
      pass      <= 1'b0;
`ifdef SWEEP_COMPARE_EN
      exp_r        <= 8'd0;
      mismatch_cnt <= 4'd0;
      fail_idx     <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            idx       <= 3'd0;
            {a, b, c} <= 3'd0;
            busy      <= 1'b1;
            table_out <= 8'd0;
            pass      <= 1'b0;
`ifdef SWEEP_COMPARE_EN
            exp_r        <= expected;
            mismatch_cnt <= 4'd0;
            fail_idx     <= 3'd0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (settle_zero) begin
            state <= SAMPLE;
          end else begin
            state <= DRIVE;
          end
        end
        SAMPLE: begin
          table_out <= table_next;
          if (last_vec) begin
            state     <= DONE;
            {a, b, c} <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b1;
`ifdef SWEEP_COMPARE_EN
            pass         <= (diff == 8'd0);
            mismatch_cnt <= popcount8(diff);
            fail_idx     <= lowest_set(diff);
`else
            pass         <= 1'b1;
`endif
          end else begin
            state     <= DRIVE;
            idx       <= idx + 3'd1;
            {a, b, c} <= idx + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Scoreboard bench for circuit_sweep_ctrl: random swept circuits and golden tables,
// start toggling/holding, mid-sweep reset, plus a SETTLE_CYCLES=3 instance.
module tb_circuit_sweep_ctrl;

  localparam int P  = 2;  // cycles per vector at SETTLE_CYCLES=1
  localparam int P3 = 4;  // cycles per vector at SETTLE_CYCLES=3

  typedef struct packed {
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] mc;
    logic [2:0] fi;
  } res_t;

  typedef struct {
    res_t r;
    int   done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, y, a, b, c, busy, done, pass;
  logic [7:0] expected, table_out, circ_tt;
  logic [3:0] mismatch_cnt;
  logic [2:0] fail_idx;

  logic       rst3, start3, y3, a3, b3, c3, busy3, done3, pass3;
  logic [7:0] expected3, table3, circ3;
  logic [3:0] mc3;
  logic [2:0] fi3;

  assign y  = circ_tt[{a, b, c}];
  assign y3 = circ3[{a3, b3, c3}];

  circuit_sweep_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .y(y),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .table_out(table_out),
    .pass(pass), .mismatch_cnt(mismatch_cnt), .fail_idx(fail_idx)
  );

  circuit_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .expected(expected3), .y(y3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .table_out(table3),
    .pass(pass3), .mismatch_cnt(mc3), .fail_idx(fi3)
  );

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   acc = 0;
  int   acc3 = 0;
  bit   active = 1'b0;
  bit   active3 = 1'b0;
  bit   mon_en = 1'b0;
  res_t last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the captured table is the circuit's truth table; compare follows from it.
  function automatic res_t model(input logic [7:0] circ, input logic [7:0] gold);
    res_t r;
    r.tbl = circ;
`ifdef SWEEP_COMPARE_EN
    r.pass = (circ == gold);
    r.mc   = 4'($countones(circ ^ gold));
    r.fi   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (circ[k] != gold[k]) r.fi = 3'(k);
    end
`else
    r.pass = 1'b1;
    r.mc   = 4'd0;
    r.fi   = 3'd0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the main instance: control timeline, held results, and done pops.
  always @(negedge clk) begin : mon
    int   off;
    logic busy_e, done_e;
    logic [2:0] abc_e;
    exp_t e;
    if (mon_en) begin
      off    = cyc - acc;
      busy_e = active && off >= 0 && off < 8 * P;
      abc_e  = busy_e ? 3'(off / P) : 3'd0;
      done_e = active && off == 8 * P;
      check("ctrl", {busy, a, b, c, done}, {busy_e, abc_e, done_e});
      if (!active) check("hold", {table_out, pass, mismatch_cnt, fail_idx}, last);
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done=1 required done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("result", {table_out, pass, mismatch_cnt, fail_idx}, e.r);
          check("latency", 64'(cyc), 64'(e.done_cyc));
          last = e.r;
          done_cnt++;
        end
      end
    end
  end

  // Monitor for the SETTLE_CYCLES=3 instance.
  always @(negedge clk) begin : mon3
    int   off;
    logic busy_e, done_e;
    logic [2:0] abc_e;
    if (mon_en) begin
      off    = cyc - acc3;
      busy_e = active3 && off >= 0 && off < 8 * P3;
      abc_e  = busy_e ? 3'(off / P3) : 3'd0;
      done_e = active3 && off == 8 * P3;
      check("s3_ctrl", {busy3, a3, b3, c3, done3}, {busy_e, abc_e, done_e});
      if (done3) check("s3_table", {table3, pass3}, {8'hEA, 1'b1});
    end
  end

  task automatic wait_done(input int mode);
    int d0;
    int waited;
    d0     = done_cnt;
    waited = 0;
    while (done_cnt == d0 && waited < 200) begin
      step();
      waited++;
      if (mode == 1) start = (cyc <= acc + 8 * P) ? ~start : 1'b0;
    end
    if (waited >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done required done within 200 cycles");
    end
    active = 1'b0;
  endtask

  // mode 0: single pulse, 1: toggle start during sweep, 2: hold start through DONE.
  task automatic run_sweep(input logic [7:0] circ, input logic [7:0] gold, input int mode);
    circ_tt  = circ;
    expected = gold;
    start    = 1'b1;
    step();
    acc = cyc;
    sb.push_back('{model(circ, gold), cyc + 8 * P});
    active = 1'b1;
    start  = (mode == 2);
    wait_done(mode);
    if (mode == 2) begin
      step();
      acc = cyc;
      sb.push_back('{model(circ, gold), cyc + 8 * P});
      active = 1'b1;
      start  = 1'b0;
      wait_done(0);
    end
  endtask

  task automatic reset_abort();
    circ_tt  = 8'($urandom);
    expected = 8'($urandom);
    start    = 1'b1;
    step();
    acc = cyc;
    sb.push_back('{model(circ_tt, expected), cyc + 8 * P});
    active = 1'b1;
    start  = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    active = 1'b0;
    sb.delete();
    last = '0;
    repeat (20) step();
  endtask

  initial begin
    logic [7:0] rc;
    rst       = 1'b1;
    rst3      = 1'b1;
    start     = 1'b0;
    start3    = 1'b0;
    circ_tt   = 8'h00;
    expected  = 8'h00;
    circ3     = 8'hEA;
    expected3 = 8'hEA;
    repeat (3) step();
    rst    = 1'b0;
    rst3   = 1'b0;
    mon_en = 1'b1;
    repeat (2) step();

    run_sweep(8'hEA, 8'hEA, 0);
    run_sweep(8'hEA, 8'hE8, 0);
    run_sweep(8'hEA, 8'h00, 0);
    run_sweep(8'hEA, 8'hEA, 1);
    run_sweep(8'hEA, 8'h5A, 2);
    reset_abort();
    run_sweep(8'hEA, 8'hEA, 0);

    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    last  = '0;
    repeat (5) step();

    for (int i = 0; i < 8; i++) begin
      rc = 8'($urandom);
      run_sweep(rc, ($urandom_range(0, 1) == 0) ? rc : rc ^ 8'($urandom), 0);
    end

    start3 = 1'b1;
    step();
    acc3    = cyc;
    active3 = 1'b1;
    start3  = 1'b0;
    repeat (8 * P3 + 4) step();
    active3 = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/circuit_sweep_ctrl.md
CIRCUIT_SWEEP_CTRL -- requirements
Module: circuit_sweep_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, 1, cycles the inputs are held before y is sampled (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a full 8-vector sweep.
REQ-005 SHALL have port: expected  input  8  golden truth table; bit k = expected y for {a,b,c}=k, a = MSB.
REQ-006 SHALL have port: y  input  1  combinational output of the swept 3-input circuit.
REQ-007 SHALL have ports: a, b, c  output  1 each  drive the swept circuit's inputs.
REQ-008 SHALL have port: busy  output  1  sweep in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse at sweep completion.
REQ-010 SHALL have port: table_out  output  8  captured truth table; bit k = y sampled with {a,b,c}=k.
REQ-011 SHALL have port: pass  output  1  table_out == expected.
REQ-012 SHALL have port: mismatch_cnt  output  4  number of differing bits (0..8).
REQ-013 SHALL have port: fail_idx  output  3  lowest mismatching index; 0 when no mismatch.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 In IDLE, start=1 SHALL latch expected, clear table_out, mismatch_cnt, fail_idx and pass, set idx=0, and enter DRIVE on the next cycle.
REQ-016 In DRIVE/SAMPLE, {a,b,c} SHALL equal idx registered; in IDLE and DONE, {a,b,c} SHALL be 3'b000.
REQ-017 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by a settle counter, and then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle: table_out[idx]<=y; if idx==7 go to DONE, else idx<=idx+1 and go to DRIVE.
REQ-019 DONE SHALL last one cycle with done=1 and pass/mismatch_cnt/fail_idx updated; the FSM then returns to IDLE.
REQ-020 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-021 Latency SHALL be: start sampled at cycle 0 gives done at cycle 8*(SETTLE_CYCLES+1)+1 (17 for the default).
REQ-022 start SHALL be ignored while busy=1 or done=1; start held high in IDLE after DONE SHALL begin a new sweep.
REQ-023 table_out, pass, mismatch_cnt and fail_idx SHALL stay stable from DONE until the next accepted start.
REQ-024 idx SHALL NOT wrap: no vector is sampled twice and no vector is skipped.

Reset
REQ-025 With rst=1 at a clock edge, the FSM SHALL go to IDLE, and idx, the settle counter, a, b, c, busy, done, table_out, pass, mismatch_cnt and fail_idx SHALL all be 0.
REQ-026 Reset mid-sweep SHALL abort the sweep with no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 With macro SWEEP_COMPARE_EN defined, pass, mismatch_cnt and fail_idx SHALL be computed per REQ-019 from the latched expected.
REQ-028 Without SWEEP_COMPARE_EN, expected SHALL be unused, the compare logic SHALL be absent, pass SHALL be 1 at DONE (0 after reset), and mismatch_cnt and fail_idx SHALL be constant 0.

Structure
REQ-029 Package circuit_sweep_pkg SHALL hold the state enum, NUM_VEC=8, IDX_W=3 and CNT_W=4.
REQ-030 Sub-module sweep_settle_cnt (load/decrement, zero flag) SHALL implement the DRIVE timer; the swept circuit SHALL be instantiated by the bench or system, not inside this block.

Verification
REQ-031 Bench model y=(a&b)|c, expected=8'hEA, SETTLE_CYCLES=1, start pulse at cycle 0 -> done at cycle 17, table_out=8'hEA, pass=1, mismatch_cnt=0, fail_idx=0.
REQ-032 Same model, expected=8'hE8 -> table_out=8'hEA, pass=0, mismatch_cnt=1, fail_idx=1.
REQ-033 SETTLE_CYCLES=3 -> done at cycle 33, and each {a,b,c} value held 4 cycles in the order 0..7.
REQ-034 rst asserted at cycle 9 of a sweep -> all outputs 0 next cycle, no done pulse; a new start then completes normally.
REQ-035 start toggled every cycle during a sweep -> single done pulse at cycle 17, results unaffected.
REQ-036 Build without SWEEP_COMPARE_EN, expected=8'h00 -> pass=1 and mismatch_cnt=0 at done, table_out=8'hEA.
